// File: rtl/wb_uart_cmd_master.sv
// UART byte-stream command decoder acting as a single-cycle classic Wishbone master.
// Decodes write/read frames, runs one bus cycle, and returns status plus read data as bytes.
module wb_uart_cmd_master #(
  parameter int ACK_TIMEOUT  = 255,
  parameter int BYTE_TIMEOUT = 65535,
  parameter int TO_W         = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  input  logic        ack_i,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_BUS, S_RESP, S_RDATA} state_t;

  localparam logic [TO_W-1:0] ACK_LIM  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [TO_W-1:0] BYTE_LIM = TO_W'(BYTE_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX   = '1;
  localparam logic [7:0]      ST_ACK   = 8'h4B;
  localparam logic [7:0]      ST_TO    = 8'h45;

  state_t          r_state, w_next;
  logic            r_we, r_err;
  logic [31:0]     r_adr, r_dat, r_rdat;
  logic [7:0]      r_status;
  logic [1:0]      r_cnt;
  logic [TO_W-1:0] r_to;
  logic            w_rx_state, w_rx_fire, w_tx_fire, w_ack, w_ack_to, w_byte_to;

  assign sel_o  = 4'hF;
  assign adr_o  = r_adr;
  assign dat_o  = r_dat;
  assign we_o   = r_we;
  assign err_o  = r_err;
  assign busy_o = (r_state != S_IDLE);
  assign cyc_o  = (r_state == S_BUS);
  assign stb_o  = (r_state == S_BUS);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_rx_state = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_WDATA);
    // Gating by reset keeps the receiver stalled while reset is held.
    rx_ready_o = w_rx_state & rst_n_i;
    tx_valid_o = (r_state == S_RESP) || (r_state == S_RDATA);
    tx_data_o  = 8'h00;
    if (r_state == S_RESP) tx_data_o = r_status;
    else if (r_state == S_RDATA) begin
      case (r_cnt)
        2'd0:    tx_data_o = r_rdat[31:24];
        2'd1:    tx_data_o = r_rdat[23:16];
        2'd2:    tx_data_o = r_rdat[15:8];
        default: tx_data_o = r_rdat[7:0];
      endcase
    end
    w_rx_fire = rx_valid_i & rx_ready_o;
    w_tx_fire = tx_valid_o & tx_ready_i;
    w_ack     = (r_state == S_BUS) & ack_i;
    w_ack_to  = (r_state == S_BUS) & ~ack_i & (r_to == ACK_LIM);
    w_byte_to = ((r_state == S_ADDR) || (r_state == S_WDATA)) & ~w_rx_fire & (r_to == BYTE_LIM);
    case (r_state)
      S_IDLE:  if (w_rx_fire && (rx_data_i == 8'h57 || rx_data_i == 8'h52)) w_next = S_ADDR;
      S_ADDR: begin
        if (w_byte_to) w_next = S_IDLE;
        else if (w_rx_fire && r_cnt == 2'd3) w_next = r_we ? S_WDATA : S_BUS;
      end
      S_WDATA: begin
        if (w_byte_to) w_next = S_IDLE;
        else if (w_rx_fire && r_cnt == 2'd3) w_next = S_BUS;
      end
      S_BUS:   if (w_ack || w_ack_to) w_next = S_RESP;
      S_RESP:  if (w_tx_fire) w_next = r_we ? S_IDLE : S_RDATA;
      S_RDATA: if (w_tx_fire && r_cnt == 2'd3) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_rdat   <= '0;
      r_status <= 8'h00;
      r_cnt    <= 2'd0;
      r_to     <= '0;
    end else begin
      r_err <= w_ack_to | w_byte_to;
      case (r_state)
        S_IDLE: if (w_rx_fire && (rx_data_i == 8'h57 || rx_data_i == 8'h52)) begin
          r_we  <= (rx_data_i == 8'h57);
          r_cnt <= 2'd0;
          r_to  <= '0;
        end
        S_ADDR, S_WDATA: begin
          if (w_rx_fire) begin
            if (r_state == S_ADDR) r_adr <= {r_adr[23:0], rx_data_i};
            else                   r_dat <= {r_dat[23:0], rx_data_i};
            r_cnt <= r_cnt + 2'd1;
            r_to  <= '0;
          end else if (r_to != TO_MAX) begin
            r_to <= r_to + TO_W'(1);
          end
        end
        S_BUS: begin
          // Ack takes priority over a timeout reached in the same cycle.
          if (w_ack) begin
            r_status <= ST_ACK;
            if (!r_we) r_rdat <= dat_i;
          end else if (w_ack_to) begin
            r_status <= ST_TO;
            r_rdat   <= '0;
          end else if (r_to != TO_MAX) begin
            r_to <= r_to + TO_W'(1);
          end
        end
        S_RDATA: if (w_tx_fire) r_cnt <= r_cnt + 2'd1;
        default: ;
      endcase
    end
  end

endmodule
